// File: rtl/mux_rr_sel.sv
// Registered N:1 valid/ready mux with fixed-select or round-robin grant; 1-cycle input-to-output latency.
// The output stage loads when empty or draining, so a stalled consumer holds in_ready low on every channel.
module mux_rr_sel #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int CNTW = 16,
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [CW-1:0]      sel,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [CW-1:0]      out_ch,
  input  logic               out_ready,
  output logic [CNTW-1:0]    xfer_cnt
);

  logic          ld;
  logic          gnt_vld;
  logic [CW-1:0] gnt_ch;
  logic [CW-1:0] ptr;
  logic          xfer_in;
  logic          xfer_out;
  logic [DW-1:0] gnt_dat;

  assign ld       = !out_valid || out_ready;
  assign xfer_in  = |(in_valid & in_ready);
  assign xfer_out = out_valid && out_ready;
  assign gnt_dat  = in_data[int'(gnt_ch)*DW +: DW];

  // Round-robin scan runs from the farthest slot back to ptr so the
  // last assignment, closest to ptr, wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    if (!mode) begin
      if (int'(sel) < N_CH) begin
        gnt_vld = 1'b1;
        gnt_ch  = sel;
      end
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx = (int'(ptr) + k) % N_CH;
        if (in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_ch  = CW'(idx);
        end
      end
    end
  end

  // Gated by rst_n so no producer sees a ready while the block is held in reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = rst_n && gnt_vld && ld && (int'(gnt_ch) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (ld) begin
        out_valid <= xfer_in;
        if (xfer_in) begin
          out_data <= gnt_dat;
          out_ch   <= gnt_ch;
        end
      end
      if (xfer_in && mode) begin
        ptr <= (gnt_ch == CW'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
      end
      if (xfer_out) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_sel.sv
// Directed bench: a 4-channel instance for select, round-robin, backpressure and reset,
// and a 3-channel instance with a 4-bit counter for out-of-range select and counter wrap.
module tb_mux_rr_sel;

  logic        clk;
  logic        rst_n;

  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  logic        b_mode;
  logic [1:0]  b_sel;
  logic [2:0]  b_in_valid;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_ready;
  logic [3:0]  b_xfer_cnt;

  int checks   = 0;
  int failures = 0;

  mux_rr_sel #(.N_CH(4), .DW(8), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  mux_rr_sel #(.N_CH(3), .DW(8), .CNTW(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_ready(b_out_ready), .xfer_cnt(b_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n       = 1'b0;
    mode        = 1'b0;
    sel         = 2'd0;
    in_valid    = 4'b0000;
    in_data     = {8'hA3, 8'hA5, 8'hA1, 8'hA0};
    out_ready   = 1'b0;
    b_mode      = 1'b0;
    b_sel       = 2'd0;
    b_in_valid  = 3'b000;
    b_in_data   = {8'hB2, 8'hB1, 8'hB0};
    b_out_ready = 1'b0;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fixed select
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("sel2_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("sel2_out_valid", 32'(out_valid), 32'd1);
    chk("sel2_out_data", 32'(out_data), 32'hA5);
    chk("sel2_out_ch", 32'(out_ch), 32'd2);
    sel = 2'd3;
    #1 chk("sel3_in_ready", 32'(in_ready), 32'b1000);
    tick();
    chk("sel3_out_data", 32'(out_data), 32'hA3);
    chk("sel3_out_ch", 32'(out_ch), 32'd3);
    chk("sel3_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // Selected channel idle: no transfer, other valid channels ignored
    sel = 2'd1; in_valid = 4'b1101;
    #1 chk("sel1_idle_in_ready", 32'(in_ready), 32'b0010);
    tick();
    chk("sel1_idle_out_valid", 32'(out_valid), 32'd0);
    chk("sel1_idle_out_data", 32'(out_data), 32'hA3);
    chk("sel1_idle_out_ch", 32'(out_ch), 32'd3);
    chk("sel1_idle_xfer_cnt", 32'(xfer_cnt), 32'd2);

    // Reset while a word is held
    sel = 2'd2; in_valid = 4'b1111;
    tick();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_ch", 32'(out_ch), 32'd0);
    chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;

    // Round-robin over four valid channels
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1 chk("rr_first_in_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_out_ch", 32'(out_ch), 32'(i % 4));
    end
    in_valid = 4'b0000;
    tick();
    chk("rr_xfer_cnt", 32'(xfer_cnt), 32'd8);
    chk("rr_drained_out_valid", 32'(out_valid), 32'd0);
    chk("rr_hold_out_ch", 32'(out_ch), 32'd3);

    // Sparse round-robin with pointer wrap
    in_valid = 4'b1010;
    #1 chk("sparse_in_ready0", 32'(in_ready), 32'b0010);
    tick();
    chk("sparse_out_ch0", 32'(out_ch), 32'd1);
    chk("sparse_in_ready1", 32'(in_ready), 32'b1000);
    tick();
    chk("sparse_out_ch1", 32'(out_ch), 32'd3);
    in_valid = 4'b0010;
    #1 chk("sparse_in_ready2", 32'(in_ready), 32'b0010);
    tick();
    chk("sparse_out_ch2", 32'(out_ch), 32'd1);
    chk("sparse_xfer_cnt", 32'(xfer_cnt), 32'd10);

    // Backpressure then drain+load in the same cycle
    out_ready = 1'b0; in_valid = 4'b1111;
    #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data", 32'(out_data), 32'hA1);
      chk("bp_out_ch", 32'(out_ch), 32'd1);
      chk("bp_xfer_cnt", 32'(xfer_cnt), 32'd10);
      chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk("bp_release_out_valid", 32'(out_valid), 32'd1);
    chk("bp_release_out_data", 32'(out_data), 32'hA5);
    chk("bp_release_out_ch", 32'(out_ch), 32'd2);
    chk("bp_release_xfer_cnt", 32'(xfer_cnt), 32'd11);

    // Three-channel instance: out-of-range select
    b_mode = 1'b0; b_sel = 2'd3; b_in_valid = 3'b111; b_out_ready = 1'b1;
    #1 chk("oor_in_ready", 32'(b_in_ready), 32'd0);
    tick();
    chk("oor_out_valid", 32'(b_out_valid), 32'd0);
    chk("oor_xfer_cnt", 32'(b_xfer_cnt), 32'd0);
    b_sel = 2'd2;
    #1 chk("n3_sel2_in_ready", 32'(b_in_ready), 32'b100);
    b_mode = 1'b1;
    #1 chk("n3_rr_in_ready", 32'(b_in_ready), 32'b001);

    // Counter wrap: 17 handshakes on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      tick();
      chk("n3_rr_out_ch", 32'(b_out_ch), 32'(i % 3));
      chk("n3_rr_out_data", 32'(b_out_data), 32'(8'hB0 + 8'(i % 3)));
    end
    chk("wrap_cnt_at_16", 32'(b_xfer_cnt), 32'd0);
    b_in_valid = 3'b000;
    tick();
    chk("wrap_cnt_at_17", 32'(b_xfer_cnt), 32'd1);
    chk("wrap_out_valid", 32'(b_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
